// File: rtl/tblock_dispatcher_pkg.sv
// Shared types and helpers for the thread-block dispatcher.
// Holds the FSM state encoding and the round-robin first-one search used by both arbiters.
package tblock_dispatcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } disp_state_e;

    localparam int unsigned MaxReq = 32;

    // Index of the first set bit at or after ptr, wrapping within num requesters.
    function automatic int unsigned rr_first(input logic [MaxReq-1:0] req,
                                             input int unsigned       ptr,
                                             input int unsigned       num);
        int unsigned idx;
        logic        found;
        rr_first = 0;
        found    = 1'b0;
        for (int unsigned i = 0; i < MaxReq; i++) begin
            if (i < num) begin
                idx = ptr + i;
                if (idx >= num) begin
                    idx = idx - num;
                end
                if (!found && req[idx[4:0]]) begin
                    found    = 1'b1;
                    rr_first = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/tblock_done_arbiter.sv
// Round-robin valid/ready arbiter with a payload mux.
// The grant is gated by en_i; the pointer moves past the winner only on a granted cycle.
module tblock_done_arbiter #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned DataWidth = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq*DataWidth-1:0]   data_i,
    input  logic                          en_i,
    output logic [NumReq-1:0]             gnt_o,
    output logic [DataWidth-1:0]          data_o
);
    import tblock_dispatcher_pkg::*;

    localparam int unsigned PtrWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [PtrWidth-1:0] ptr_q, ptr_d;
    logic [PtrWidth-1:0] sel;

    // Winner selection and pointer advance.
    always_comb begin
        sel   = PtrWidth'(rr_first(MaxReq'(req_i), 32'(ptr_q), NumReq));
        gnt_o = '0;
        ptr_d = ptr_q;
        if (en_i && (|req_i)) begin
            gnt_o[sel] = 1'b1;
            ptr_d      = ((32'(sel) + 32'd1) == NumReq) ? '0 : PtrWidth'(32'(sel) + 32'd1);
        end
    end

    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (sel == PtrWidth'(i)) begin
                data_o = data_i[i*DataWidth +: DataWidth];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tblock_dispatcher.sv
// Kernel launch sequencer: hands thread blocks to free clusters round-robin,
// tracks in-flight block ids and reports kernel completion once all blocks retire.
module tblock_dispatcher #(
    parameter int unsigned NumClusters   = 2,
    parameter int unsigned PcWidth       = 16,
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned TblockIdxBits = 8,
    parameter int unsigned TblockIdBits  = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                launch_valid_i,
    output logic                                launch_ready_o,
    input  logic [PcWidth-1:0]                  launch_pc_i,
    input  logic [AddressWidth-1:0]             launch_dp_addr_i,
    input  logic [TblockIdxBits:0]              launch_num_tblocks_i,
    output logic                                kernel_done_o,
    input  logic                                kernel_done_ready_i,
    input  logic [NumClusters-1:0]              warp_free_i,
    output logic [NumClusters-1:0]              allocate_warp_o,
    output logic [PcWidth-1:0]                  allocate_pc_o,
    output logic [AddressWidth-1:0]             allocate_dp_addr_o,
    output logic [TblockIdxBits-1:0]            allocate_tblock_idx_o,
    output logic [TblockIdBits-1:0]             allocate_tblock_id_o,
    input  logic [NumClusters-1:0]              tblock_done_i,
    input  logic [NumClusters*TblockIdBits-1:0] tblock_done_id_i,
    output logic [NumClusters-1:0]              tblock_done_ready_o
);
    import tblock_dispatcher_pkg::*;

    localparam int unsigned CntWidth = TblockIdxBits + 1;
    localparam int unsigned NumIds   = 2 ** TblockIdBits;

    disp_state_e               state_q, state_d;
    logic [PcWidth-1:0]        pc_q, pc_d;
    logic [AddressWidth-1:0]   dp_q, dp_d;
    logic [CntWidth-1:0]       num_q, num_d;
    logic [CntWidth-1:0]       next_idx_q, next_idx_d;
    logic [CntWidth-1:0]       retired_q, retired_d;
    logic [NumIds-1:0]         inflight_q, inflight_d;

    logic [TblockIdBits-1:0]   cand_id;
    logic [TblockIdBits-1:0]   done_id;
    logic                      dispatch_en;
    logic                      done_en;
    logic                      dispatch_fire;
    logic                      done_fire;
    logic                      disp_data_unused;

    assign cand_id     = next_idx_q[TblockIdBits-1:0];
    assign dispatch_en = (state_q == ST_DISPATCH) && !inflight_q[cand_id];
    assign done_en     = (state_q != ST_IDLE);

    // Grant selection for allocation; no payload is needed on this side.
    tblock_done_arbiter #(
        .NumReq    (NumClusters),
        .DataWidth (1)
    ) u_alloc_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (warp_free_i),
        .data_i ({NumClusters{1'b0}}),
        .en_i   (dispatch_en),
        .gnt_o  (allocate_warp_o),
        .data_o (disp_data_unused)
    );

    tblock_done_arbiter #(
        .NumReq    (NumClusters),
        .DataWidth (TblockIdBits)
    ) u_done_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (tblock_done_i),
        .data_i (tblock_done_id_i),
        .en_i   (done_en),
        .gnt_o  (tblock_done_ready_o),
        .data_o (done_id)
    );

    assign dispatch_fire = |allocate_warp_o;
    assign done_fire     = |tblock_done_ready_o;

    // Set and clear never collide: dispatch only targets an id whose bit is currently 0.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        dp_d       = dp_q;
        num_d      = num_q;
        next_idx_d = next_idx_q;
        retired_d  = retired_q;
        inflight_d = inflight_q;

        if (dispatch_fire) begin
            inflight_d[cand_id] = 1'b1;
            next_idx_d          = next_idx_q + CntWidth'(1);
        end
        if (done_fire) begin
            inflight_d[done_id] = 1'b0;
            retired_d           = retired_q + CntWidth'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (launch_valid_i) begin
                    pc_d       = launch_pc_i;
                    dp_d       = launch_dp_addr_i;
                    num_d      = launch_num_tblocks_i;
                    next_idx_d = '0;
                    retired_d  = '0;
                    state_d    = (launch_num_tblocks_i == '0) ? ST_DONE : ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                if (dispatch_fire && (next_idx_q == (num_q - CntWidth'(1)))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (retired_d == num_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (kernel_done_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            dp_q       <= '0;
            num_q      <= '0;
            next_idx_q <= '0;
            retired_q  <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            dp_q       <= dp_d;
            num_q      <= num_d;
            next_idx_q <= next_idx_d;
            retired_q  <= retired_d;
            inflight_q <= inflight_d;
        end
    end

    assign launch_ready_o        = (state_q == ST_IDLE);
    assign kernel_done_o         = (state_q == ST_DONE);
    assign allocate_pc_o         = pc_q;
    assign allocate_dp_addr_o    = dp_q;
    assign allocate_tblock_idx_o = next_idx_q[TblockIdxBits-1:0];
    assign allocate_tblock_id_o  = cand_id;

    // A cluster must only retire ids that are currently in flight.
    ast_done_inflight: assert property (@(posedge clk_i) disable iff (!rst_ni)
        done_fire |-> inflight_q[done_id])
        else $error("tblock done for id not in flight");

endmodule
